// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: three-requester arbiter in front of one synchronous RAM
// port (port B). Each transaction takes ACCESS (address/data/strobe
// presented to the RAM) followed by RESP (ack, read data from ram_q).
//
// Build option: define MEMARB_ROUND_ROBIN_EN for rotating priority
// (requester after owner first). Default build is fixed priority 0 > 1 > 2.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high
//   req[2:0]   access request (0 CPU data, 1 display scanout, 2 peripheral)
//   we[2:0]    per-requester write enable (1 write, 0 read)
//   addr_in    packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata_in   packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt[2:0]   one-hot grant, high in ACCESS
//   ack[2:0]   one-hot completion, high in RESP
//   rdata      read data (ram_q), valid with ack of a read
//   ram_addr   registered RAM address
//   ram_data   registered RAM write data
//   ram_we     registered RAM write strobe, ACCESS only
//   ram_q      RAM read data, one cycle after address sample
//   busy       high in ACCESS and RESP
//   owner      index of current/last granted requester
//
// state  | meaning
// IDLE   | no transaction; arbitrate on any req
// ACCESS | winner's address/data/strobe on the RAM port, gnt high
// RESP   | ram_q valid, ack high; arbitrate for the next transaction
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [3*ADDR_WIDTH-1:0] addr_in,
  input  logic [3*DATA_WIDTH-1:0] wdata_in,
  output logic [2:0]              gnt,
  output logic [2:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_data,
  output logic                    ram_we,
  input  logic [DATA_WIDTH-1:0]   ram_q,
  output logic                    busy,
  output logic [1:0]              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    load;
  logic [1:0]              winner;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_we;

  // Winner is only consumed when |req, so its value with no request is moot.
  always_comb begin
    winner = 2'd0;
`ifdef MEMARB_ROUND_ROBIN_EN
    // owner resets to 2, which makes requester 0 top priority first.
    case (owner)
      2'd0: begin
        if (req[1])      winner = 2'd1;
        else if (req[2]) winner = 2'd2;
        else             winner = 2'd0;
      end
      2'd1: begin
        if (req[2])      winner = 2'd2;
        else if (req[0]) winner = 2'd0;
        else             winner = 2'd1;
      end
      default: begin
        if (req[0])      winner = 2'd0;
        else if (req[1]) winner = 2'd1;
        else             winner = 2'd2;
      end
    endcase
`else
    if (req[0])      winner = 2'd0;
    else if (req[1]) winner = 2'd1;
    else             winner = 2'd2;
`endif
  end

  always_comb begin
    sel_addr = addr_in[0 +: ADDR_WIDTH];
    sel_data = wdata_in[0 +: DATA_WIDTH];
    sel_we   = we[0];
    case (winner)
      2'd1: begin
        sel_addr = addr_in[ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wdata_in[DATA_WIDTH +: DATA_WIDTH];
        sel_we   = we[1];
      end
      2'd2: begin
        sel_addr = addr_in[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wdata_in[2*DATA_WIDTH +: DATA_WIDTH];
        sel_we   = we[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 2'd2;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Strobe is set only on entry to ACCESS, so it clears after one cycle.
      ram_we <= load & sel_we;
      if (load) begin
        owner    <= winner;
        ram_addr <= sel_addr;
        ram_data <= sel_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    gnt       = 3'b000;
    ack       = 3'b000;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = ACCESS;
          load      = 1'b1;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        gnt       = 3'b001 << owner;
        busy      = 1'b1;
      end
      RESP: begin
        ack  = 3'b001 << owner;
        busy = 1'b1;
        if (|req) begin
          state_nxt = ACCESS;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rdata = ram_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2:0]      req = 3'b000;
  logic [2:0]      we = 3'b000;
  logic [3*AW-1:0] addr_in = '0;
  logic [3*DW-1:0] wdata_in = '0;
  logic [2:0]      gnt, ack;
  logic [DW-1:0]   rdata, ram_data;
  logic [AW-1:0]   ram_addr;
  logic            ram_we, busy;
  logic [DW-1:0]   ram_q = '0;
  logic [1:0]      owner;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr_in(addr_in),
    .wdata_in(wdata_in), .gnt(gnt), .ack(ack), .rdata(rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .ram_q(ram_q), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Synchronous RAM port B: read data one cycle after address sample.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_data;
    ram_q <= ram[ram_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction occupies an access cycle and the
  // following response cycle; arbitration happens at every edge that
  // closes a cycle which is not an access cycle.
  logic [DW-1:0] ref_mem [1024];
  int            cyc = 0;
  int            acc_cyc = -100;
  int            m_owner = 2;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_we = 1'b0;

  function automatic int pick(input logic [2:0] r, input int last);
`ifdef MEMARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      cyc = 0; acc_cyc = -100; m_owner = 2; m_addr = '0; m_wdata = '0; m_we = 1'b0;
    end else begin
      cyc++;
      if (cyc - 1 == acc_cyc) begin
        if (m_we) ref_mem[m_addr] = m_wdata;
      end else if (req != 3'b000) begin
        int w;
        w       = pick(req, m_owner);
        m_owner = w;
        acc_cyc = cyc;
        m_addr  = addr_in[w*AW +: AW];
        m_wdata = wdata_in[w*DW +: DW];
        m_we    = we[w];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    begin
      logic in_acc, in_resp;
      logic [2:0] oh;
      in_acc  = !reset && (cyc == acc_cyc);
      in_resp = !reset && (cyc == acc_cyc + 1);
      oh      = 3'b001 << m_owner;
      check("m_gnt", gnt, in_acc ? oh : 3'b000);
      check("m_ack", ack, in_resp ? oh : 3'b000);
      check("m_busy", busy, in_acc || in_resp);
      check("m_ram_we", ram_we, in_acc && m_we);
      check("m_owner", owner, m_owner);
      check("m_ram_addr", ram_addr, m_addr);
      check("m_ram_data", ram_data, m_wdata);
      if (in_resp && !m_we) check("m_rdata", rdata, ref_mem[m_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int order [4];
  int got [$];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    ram[5] = 16'h1234;
    ref_mem[5] = 16'h1234;

    // Reset values
    tick(); tick();
    check("rst_owner", owner, 2'd2);
    check("rst_gnt", gnt, 3'b000);
    check("rst_ack", ack, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 10'd0);
    check("rst_ram_data", ram_data, 16'd0);
    reset = 1'b0;

    // Single read by requester 0 at address 5
    req = 3'b001; we = 3'b000; addr_in = {10'd0, 10'd0, 10'd5};
    tick();
    check("rd_gnt", gnt, 3'b001);
    check("rd_busy", busy, 1'b1);
    req = 3'b000;
    tick();
    check("rd_ack", ack, 3'b001);
    check("rd_rdata", rdata, 16'h1234);
    tick();
    check("rd_idle_busy", busy, 1'b0);
    check("rd_idle_ack", ack, 3'b000);

    // Write by requester 1 at address 511
    req = 3'b010; we = 3'b010; addr_in = {10'd0, 10'd511, 10'd0};
    wdata_in = {16'h0, 16'h00FF, 16'h0};
    tick();
    check("wr_gnt", gnt, 3'b010);
    check("wr_ram_we", ram_we, 1'b1);
    check("wr_ram_addr", ram_addr, 10'd511);
    check("wr_ram_data", ram_data, 16'h00FF);
    req = 3'b000; we = 3'b000;
    tick();
    check("wr_ack", ack, 3'b010);
    check("wr_resp_ram_we", ram_we, 1'b0);
    check("wr_resp_ram_addr", ram_addr, 10'd511);
    tick();
    check("wr_idle_ram_we", ram_we, 1'b0);
    check("wr_idle_ram_data", ram_data, 16'h00FF);

    // Readback via requester 0
    req = 3'b001; addr_in = {10'd0, 10'd0, 10'd511};
    tick();
    req = 3'b000;
    tick();
    check("rb_ack", ack, 3'b001);
    check("rb_rdata", rdata, 16'h00FF);
    tick();

    // req0 dropped during ACCESS still completes, no second grant
    req = 3'b001; we = 3'b000; addr_in = {10'd0, 10'd0, 10'd5};
    tick();
    check("drop_gnt", gnt, 3'b001);
    req = 3'b000;
    tick();
    check("drop_ack", ack, 3'b001);
    check("drop_rdata", rdata, 16'h1234);
    tick();
    check("drop_no_gnt", gnt, 3'b000);
    check("drop_idle", busy, 1'b0);
    tick();
    check("drop_no_gnt2", gnt, 3'b000);

    // Reset pulsed during a write's ACCESS cycle
    req = 3'b001; we = 3'b001; addr_in = {10'd0, 10'd0, 10'd9};
    wdata_in = {16'h0, 16'h0, 16'hABCD};
    tick();
    check("abort_ram_we_before", ram_we, 1'b1);
    req = 3'b000; we = 3'b000;
    #2 reset = 1'b1;
    #1;
    check("abort_ram_we_async", ram_we, 1'b0);
    check("abort_busy_async", busy, 1'b0);
    check("abort_gnt_async", gnt, 3'b000);
    tick();
    check("abort_no_ack", ack, 3'b000);
    reset = 1'b0;
    tick();
    check("abort_idle_ack", ack, 3'b000);
    check("abort_idle_busy", busy, 1'b0);
    req = 3'b001; addr_in = {10'd0, 10'd0, 10'd9};
    tick();
    req = 3'b000;
    tick();
    check("abort_rb_ack", ack, 3'b001);
    check("abort_rb_rdata", rdata, 16'h0000);
    tick();

    // All three requesting continuously, from a fresh priority pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
    order = '{0, 1, 2, 0};
`else
    order = '{0, 0, 0, 0};
`endif
    req = 3'b111; we = 3'b000; addr_in = {10'd7, 10'd511, 10'd5};
    for (int i = 0; i < 8; i++) begin
      tick();
      check("all_busy", busy, 1'b1);
      if (i % 2 == 0) check("all_gnt", gnt, 3'b001 << order[i/2]);
      else            check("all_gnt_resp", gnt, 3'b000);
      for (int b = 0; b < 3; b++) if (gnt[b]) got.push_back(b);
    end
    check("all_gnt_count", got.size(), 4);
    req = 3'b000;
    tick();
    check("all_end_idle", busy, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
